// File: rtl/data_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : data_store_buffer
// Description : Posted-write buffer between the CPU memory stage and a
//               two-cycle-per-store data memory. Stores are queued in a FIFO
//               without stalling and drained in the background; loads pass
//               straight through unless an older queued store hits the same
//               word.
// Revision    : 1.0 - initial release
// ============================================================================
module data_store_buffer #(
    parameter int DEPTH       = 4,
    parameter int WORD_ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    // CPU memory-stage side
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_write_data,
    input  logic        cpu_memwrite,
    input  logic        cpu_memread,
    input  logic [3:0]  cpu_sign_mask,
    output logic [31:0] cpu_read_data,
    output logic        cpu_stall,
    // Data memory side
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // FIFO storage (no reset needed: validity is tracked by count/pointers)
    logic [31:0]        fifo_addr_q [DEPTH];
    logic [31:0]        fifo_data_q [DEPTH];
    logic [3:0]         fifo_mask_q [DEPTH];

    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    state_t             state_q, state_d;

    // Values presented to data memory for the store in flight; held while
    // the memory completes the write and between transactions.
    logic [31:0]        out_addr_q;
    logic [31:0]        out_data_q;
    logic [3:0]         out_mask_q;

    logic               conflict;
    logic               load_issue;
    logic               store_req;
    logic               push;
    logic               pop;
    logic               drain_start;

    // Word-address match against every occupied FIFO slot, including the
    // head entry that may currently be in flight.
    always_comb begin
        logic [c_ptr_w-1:0] offset;
        conflict = 1'b0;
        offset   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = c_ptr_w'(i) - rd_ptr_q;
            if (({1'b0, offset} < count_q) &&
                (fifo_addr_q[i][WORD_ADDR_W+1:2] == cpu_addr[WORD_ADDR_W+1:2])) begin
                conflict = 1'b1;
            end
        end
    end

    // Request arbitration: an issuable load wins over starting a drain;
    // a combined read/write request is treated purely as a load.
    always_comb begin
        load_issue  = cpu_memread && (state_q == S_IDLE) && !conflict;
        store_req   = cpu_memwrite && !cpu_memread;
        pop         = (state_q == S_WAIT);
        push        = store_req && ((count_q != c_full) || pop);
        drain_start = (state_q == S_IDLE) && (count_q != '0) &&
                      !load_issue && !mem_clk_stall;
        cpu_stall   = (cpu_memread && !load_issue) || (store_req && !push);
    end

    // Downstream drive: load address straight through, else the head entry
    // when a drain starts, else the held values of the last store.
    always_comb begin
        mem_memread    = load_issue;
        mem_memwrite   = drain_start;
        mem_addr       = out_addr_q;
        mem_write_data = out_data_q;
        mem_sign_mask  = out_mask_q;
        if (load_issue) begin
            mem_addr      = cpu_addr;
            mem_sign_mask = cpu_sign_mask;
        end else if (drain_start) begin
            mem_addr       = fifo_addr_q[rd_ptr_q];
            mem_write_data = fifo_data_q[rd_ptr_q];
            mem_sign_mask  = fifo_mask_q[rd_ptr_q];
        end
        cpu_read_data = mem_read_data;
    end

    // Next-state for pointers, occupancy and the drain FSM.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
        end
        if (push && !pop) begin
            count_d = count_q + c_cnt_w'(1);
        end else if (pop && !push) begin
            count_d = count_q - c_cnt_w'(1);
        end
        case (state_q)
            S_IDLE:  if (drain_start) state_d = S_WAIT;
            S_WAIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and held downstream values; reset discards the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_mask_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            if (drain_start) begin
                out_addr_q <= fifo_addr_q[rd_ptr_q];
                out_data_q <= fifo_data_q[rd_ptr_q];
                out_mask_q <= fifo_mask_q[rd_ptr_q];
            end
        end
    end

    // FIFO write port.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= cpu_addr;
            fifo_data_q[wr_ptr_q] <= cpu_write_data;
            fifo_mask_q[wr_ptr_q] <= cpu_sign_mask;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_store_buffer
// Description : Directed, table-driven bench for data_store_buffer with a
//               small two-cycle data memory model behind it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_store_buffer;

    localparam logic [3:0] MW = 4'b0010;   // word access in the memory model
    localparam logic [3:0] MB = 4'b0000;   // byte access in the memory model

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_write_data = '0;
    logic        cpu_memwrite = 1'b0;
    logic        cpu_memread = 1'b0;
    logic [3:0]  cpu_sign_mask = '0;
    logic [31:0] cpu_read_data;
    logic        cpu_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data;
    logic        mem_clk_stall;

    logic        hold = 1'b0;     // extra busy from the bench to block draining
    logic        busy_q = 1'b0;
    logic [31:0] mem [0:1023];
    logic [31:0] rdata_q = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    always #5 clk = ~clk;

    data_store_buffer #(.DEPTH(4), .WORD_ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
        .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
        .cpu_sign_mask(cpu_sign_mask), .cpu_read_data(cpu_read_data),
        .cpu_stall(cpu_stall),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
        .mem_clk_stall(mem_clk_stall)
    );

    // Data memory model: busy the cycle after a store, read data next cycle.
    assign mem_clk_stall = busy_q | hold;
    assign mem_read_data = rdata_q;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    end

    always @(posedge clk) begin
        busy_q <= mem_memwrite;
        if (mem_memwrite) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_write_data);
            case (mem_sign_mask[1:0])
                2'd0:    mem[mem_addr[11:2]][8*mem_addr[1:0] +: 8] <= mem_write_data[7:0];
                2'd1:    mem[mem_addr[11:2]][16*mem_addr[1] +: 16] <= mem_write_data[15:0];
                default: mem[mem_addr[11:2]] <= mem_write_data;
            endcase
        end
        if (mem_memread) rdata_q <= mem[mem_addr[11:2]];
    end

    typedef struct {
        logic        we, re;
        logic [31:0] addr, wdata;
        logic [3:0]  mask;
        logic        hold;
        logic        e_stall, e_mw, e_mr;
        logic        chk_addr;
        logic [31:0] e_addr;
        logic        chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(logic we, logic re, logic [31:0] addr, logic [31:0] wdata,
                                logic [3:0] mask, logic hd, logic es, logic emw, logic emr,
                                logic ca, logic [31:0] ea, logic cr, logic [31:0] er);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.wdata = wdata; v.mask = mask; v.hold = hd;
        v.e_stall = es; v.e_mw = emw; v.e_mr = emr;
        v.chk_addr = ca; v.e_addr = ea; v.chk_rd = cr; v.e_rd = er;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic we, logic re, logic [31:0] a, logic [31:0] d,
                         logic [3:0] m, logic hd);
        cpu_memwrite = we; cpu_memread = re; cpu_addr = a;
        cpu_write_data = d; cpu_sign_mask = m; hold = hd;
    endtask

    logic [31:0] exp_la [10];
    logic [31:0] exp_ld [10];
    int          log_before;

    initial begin
        // single store, then load it back
        vecs.push_back(mk(1,0,32'h10,32'hDEADBEEF,MW,0, 0,0,0, 1,32'h0,  0,0));
        vecs.push_back(mk(0,0,0,0,0,0,                 0,1,0, 1,32'h10, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,                 0,0,0, 1,32'h10, 0,0));
        vecs.push_back(mk(0,1,32'h10,0,MW,0,           0,0,1, 1,32'h10, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,                 0,0,0, 1,32'h10, 1,32'hDEADBEEF));
        // five stores with the drain held off: fifth stalls until first pop
        vecs.push_back(mk(1,0,32'h00,32'hA0000000,MW,1, 0,0,0, 0,0, 0,0));
        vecs.push_back(mk(1,0,32'h04,32'hA0000001,MW,1, 0,0,0, 0,0, 0,0));
        vecs.push_back(mk(1,0,32'h08,32'hA0000002,MW,1, 0,0,0, 0,0, 0,0));
        vecs.push_back(mk(1,0,32'h0C,32'hA0000003,MW,1, 0,0,0, 0,0, 0,0));
        vecs.push_back(mk(1,0,32'h10,32'hA0000004,MW,1, 1,0,0, 0,0, 0,0));
        vecs.push_back(mk(1,0,32'h10,32'hA0000004,MW,0, 1,1,0, 1,32'h00, 0,0));
        vecs.push_back(mk(1,0,32'h10,32'hA0000004,MW,0, 0,0,0, 1,32'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,1,0, 1,32'h04, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 1,32'h04, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,1,0, 1,32'h08, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 1,32'h08, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,1,0, 1,32'h0C, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 1,32'h0C, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,1,0, 1,32'h10, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 1,32'h10, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 1,32'h10, 0,0));
        // non-conflicting load beats the drain, drain resumes next cycle
        vecs.push_back(mk(1,0,32'h00,32'h5A5A0001,MW,1, 0,0,0, 0,0, 0,0));
        vecs.push_back(mk(1,0,32'h04,32'h5A5A0002,MW,1, 0,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,1,32'h40,0,MW,0,            0,0,1, 1,32'h40, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,                  0,1,0, 1,32'h00, 1,32'h0));
        vecs.push_back(mk(0,0,0,0,0,0,                  0,0,0, 1,32'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,                  0,1,0, 1,32'h04, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,                  0,0,0, 1,32'h04, 0,0));
        // load during WAIT: one stall cycle
        vecs.push_back(mk(1,0,32'h30,32'hC0C0C0C0,MW,0, 0,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,                  0,1,0, 1,32'h30, 0,0));
        vecs.push_back(mk(0,1,32'h80,0,MW,0,            1,0,0, 1,32'h30, 0,0));
        vecs.push_back(mk(0,1,32'h80,0,MW,0,            0,0,1, 1,32'h80, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,                  0,0,0, 1,32'h30, 1,32'h0));
        // conflicting load waits for the byte store to drain
        vecs.push_back(mk(1,0,32'h21,32'h00000055,MB,0, 0,0,0, 1,32'h30, 0,0));
        vecs.push_back(mk(0,1,32'h20,0,MW,0,            1,1,0, 1,32'h21, 0,0));
        vecs.push_back(mk(0,1,32'h20,0,MW,0,            1,0,0, 1,32'h21, 0,0));
        vecs.push_back(mk(0,1,32'h20,0,MW,0,            0,0,1, 1,32'h20, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,                  0,0,0, 1,32'h21, 1,32'h00005500));
        // read+write together is a load only
        vecs.push_back(mk(1,1,32'h44,32'h12345678,MW,0, 0,0,1, 1,32'h44, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,                  0,0,0, 1,32'h21, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,                  0,0,0, 1,32'h21, 0,0));

        exp_la = '{32'h10, 32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h00, 32'h04, 32'h30, 32'h21};
        exp_ld = '{32'hDEADBEEF, 32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003,
                   32'hA0000004, 32'h5A5A0001, 32'h5A5A0002, 32'hC0C0C0C0, 32'h00000055};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset cpu_stall", 32'(cpu_stall), 0);
        chk("reset mem_memwrite", 32'(mem_memwrite), 0);
        chk("reset mem_memread", 32'(mem_memread), 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_write_data", mem_write_data, 0);
        chk("reset mem_sign_mask", 32'(mem_sign_mask), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].mask, vecs[i].hold);
            @(negedge clk);
            chk($sformatf("v%0d cpu_stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d mem_memwrite", i), 32'(mem_memwrite), 32'(vecs[i].e_mw));
            chk($sformatf("v%0d mem_memread", i), 32'(mem_memread), 32'(vecs[i].e_mr));
            chk($sformatf("v%0d rw_exclusive", i), 32'(mem_memwrite & mem_memread), 0);
            if (vecs[i].chk_addr)
                chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
            if (vecs[i].chk_rd)
                chk($sformatf("v%0d cpu_read_data", i), cpu_read_data, vecs[i].e_rd);
        end

        // store order and data as seen by the memory
        chk("store log length", 32'(log_addr.size()), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < log_addr.size()) begin
                chk($sformatf("store%0d addr", i), log_addr[i], exp_la[i]);
                chk($sformatf("store%0d data", i), log_data[i], exp_ld[i]);
            end
        end

        // reset in the middle of a drain
        @(posedge clk); #1; drive(1, 0, 32'h100, 32'hB0000000, MW, 1);
        @(posedge clk); #1; drive(1, 0, 32'h104, 32'hB0000001, MW, 1);
        @(posedge clk); #1; drive(1, 0, 32'h108, 32'hB0000002, MW, 1);
        @(posedge clk); #1; drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst drain start mem_memwrite", 32'(mem_memwrite), 1);
        chk("rst drain start mem_addr", mem_addr, 32'h100);
        @(posedge clk); #1;
        chk("rst in WAIT mem_memwrite", 32'(mem_memwrite), 0);
        chk("rst in WAIT mem_addr", mem_addr, 32'h100);
        rst_n = 1'b0;
        #1;
        chk("mid-drain reset mem_memwrite", 32'(mem_memwrite), 0);
        chk("mid-drain reset mem_memread", 32'(mem_memread), 0);
        chk("mid-drain reset cpu_stall", 32'(cpu_stall), 0);
        chk("mid-drain reset mem_addr", mem_addr, 0);
        chk("mid-drain reset mem_write_data", mem_write_data, 0);
        chk("mid-drain reset mem_sign_mask", 32'(mem_sign_mask), 0);
        log_before = log_addr.size();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("no stores after reset", 32'(log_addr.size()), 32'(log_before));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
